// File: rtl/led_pattern_seq.sv
// LED pattern sequencer between the button debouncers and the board LED pins.
// A free-running prescaler paces the position register through four display modes at four speeds.
module led_pattern_seq #(
    parameter int NLED      = 4,
    parameter int DIVW      = 25,
    parameter int FASTSHIFT = 23
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         MODE_STEP,
    input  logic                         SPEED_STEP,
    input  logic                         PAUSE_TGL,
    output logic [NLED-1:0]              LED,
    output logic [1:0]                   MODE,
    output logic [1:0]                   SPEED,
    output logic                         PAUSED,
    output logic                         TICK,
    output logic [$clog2(NLED+1)-1:0]    POS_DBG
);

    // MODE_STEP, SPEED_STEP and PAUSE_TGL are one-cycle pulses with no ready/acknowledge:
    // each one is consumed on the rising edge where it is high, and pulses in one cycle act independently.

    typedef enum logic [1:0] {
        M_BOUNCE = 2'd0,
        M_RIGHT  = 2'd1,
        M_LEFT   = 2'd2,
        M_FILL   = 2'd3
    } mode_e;

    localparam int              PW       = $clog2(NLED + 1);
    localparam int              OHW      = NLED + 1;
    localparam logic [PW-1:0]   P_ZERO   = '0;
    localparam logic [PW-1:0]   P_ONE    = PW'(1);
    localparam logic [PW-1:0]   P_TOP    = PW'(NLED - 1);
    localparam logic [PW-1:0]   P_TOP2   = PW'(NLED - 2);
    localparam logic [PW-1:0]   P_FULL   = PW'(NLED);
    localparam logic            DIR_UP   = 1'b0;
    localparam logic            DIR_DN   = 1'b1;
    localparam logic [DIVW-1:0] CNT_ONES = '1;

    logic [DIVW-1:0] cnt_q, cnt_d;
    mode_e           mode_q, mode_d;
    logic [1:0]      speed_q, speed_d;
    logic            paused_q, paused_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            dir_q, dir_d;
    logic [DIVW-1:0] tick_mask;
    logic            tick;
    logic            advance;
    logic [OHW-1:0]  one_hot;

    function automatic logic [PW-1:0] start_pos(input mode_e m);
        return (m == M_RIGHT) ? P_TOP : P_ZERO;
    endfunction

    // Tick when the low FASTSHIFT+SPEED counter bits are all ones; the current SPEED decodes it.
    always_comb begin
        tick_mask = CNT_ONES >> (DIVW - FASTSHIFT - int'(speed_q));
        tick      = ((cnt_q & tick_mask) == tick_mask);
        advance   = tick && !paused_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            mode_q   <= M_BOUNCE;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            pos_q    <= P_ZERO;
            dir_q    <= DIR_UP;
        end else begin
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q + DIVW'(1);
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q;
        pos_d    = pos_q;
        dir_d    = dir_q;

        if (SPEED_STEP) speed_d = speed_q + 2'd1;
        if (PAUSE_TGL)  paused_d = ~paused_q;

        // A mode change swallows any advance that lands in the same cycle.
        if (MODE_STEP) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pos_d  = start_pos(mode_d);
            dir_d  = DIR_UP;
        end else if (advance) begin
            case (mode_q)
                M_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q >= P_TOP) begin
                            pos_d = P_TOP2;
                            dir_d = DIR_DN;
                        end else begin
                            pos_d = pos_q + P_ONE;
                        end
                    end else begin
                        if (pos_q == P_ZERO) begin
                            pos_d = P_ONE;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - P_ONE;
                        end
                    end
                end
                M_RIGHT: pos_d = (pos_q == P_ZERO || pos_q > P_TOP) ? P_TOP : pos_q - P_ONE;
                M_LEFT:  pos_d = (pos_q >= P_TOP) ? P_ZERO : pos_q + P_ONE;
                default: pos_d = (pos_q >= P_FULL) ? P_ZERO : pos_q + P_ONE;
            endcase
        end
    end

    // One-hot is one bit wider than LED so the fill bar at pos NLED does not overflow.
    always_comb begin
        LED     = '0;
        one_hot = OHW'(1) << pos_q;
        case (mode_q)
            M_FILL:  if (pos_q <= P_FULL) LED = NLED'(one_hot - OHW'(1));
            default: if (pos_q <= P_TOP)  LED = one_hot[NLED-1:0];
        endcase
    end

    assign MODE    = mode_q;
    assign SPEED   = speed_q;
    assign PAUSED  = paused_q;
    assign TICK    = tick;
    assign POS_DBG = pos_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with NLED=4, DIVW=8, FASTSHIFT=2.
// Expected LED patterns and tick spacings are hand-computed constants.
module tb_led_pattern_seq;

  localparam int NLED       = 4;
  localparam int DIVW       = 8;
  localparam int FASTSHIFT  = 2;
  localparam int PW         = $clog2(NLED + 1);
  localparam int TICK_LIMIT = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_step = 1'b0;
  logic speed_step = 1'b0;
  logic pause_tgl = 1'b0;

  logic [NLED-1:0] led;
  logic [1:0]      mode;
  logic [1:0]      speed;
  logic            paused;
  logic            tick;
  logic [PW-1:0]   pos_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int waited;

  always #5 clk = ~clk;

  led_pattern_seq #(
    .NLED      (NLED),
    .DIVW      (DIVW),
    .FASTSHIFT (FASTSHIFT)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .MODE_STEP  (mode_step),
    .SPEED_STEP (speed_step),
    .PAUSE_TGL  (pause_tgl),
    .LED        (led),
    .MODE       (mode),
    .SPEED      (speed),
    .PAUSED     (paused),
    .TICK       (tick),
    .POS_DBG    (pos_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Leaves the bench at a falling edge where TICK is high, without consuming it.
  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < TICK_LIMIT) begin
      step();
      n++;
    end
    chk("tick_seen", 32'(tick), 1);
  endtask

  task automatic tick_adv(output int n);
    wait_tick(n);
    step();
  endtask

  task automatic pulse(input logic m, input logic s, input logic p);
    mode_step  = m;
    speed_step = s;
    pause_tgl  = p;
    step();
    mode_step  = 1'b0;
    speed_step = 1'b0;
    pause_tgl  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int exp_bounce[6] = '{'b0010, 'b0100, 'b1000, 'b0100, 'b0010, 'b0001};
    int exp_right[4]  = '{'b0100, 'b0010, 'b0001, 'b1000};
    int exp_left[4]   = '{'b0010, 'b0100, 'b1000, 'b0001};
    int exp_fill[5]   = '{'b0001, 'b0011, 'b0111, 'b1111, 'b0000};

    step();
    step();
    rst = 1'b0;

    chk("rst_led",    32'(led),     'b0001);
    chk("rst_mode",   32'(mode),    0);
    chk("rst_speed",  32'(speed),   0);
    chk("rst_paused", 32'(paused),  0);
    chk("rst_tick",   32'(tick),    0);
    chk("rst_pos",    32'(pos_dbg), 0);

    // Bounce at speed 0: tick at cnt=3,7,11,...
    for (int i = 0; i < 6; i++) begin
      tick_adv(waited);
      chk("bounce_wait", 32'(waited), 3);
      chk("bounce_led", 32'(led), 32'(exp_bounce[i]));
    end

    // Right
    pulse(1'b1, 1'b0, 1'b0);
    chk("right_mode", 32'(mode), 1);
    chk("right_start", 32'(led), 'b1000);
    for (int i = 0; i < 4; i++) begin
      tick_adv(waited);
      chk("right_led", 32'(led), 32'(exp_right[i]));
    end

    // Left
    pulse(1'b1, 1'b0, 1'b0);
    chk("left_mode", 32'(mode), 2);
    chk("left_start", 32'(led), 'b0001);
    for (int i = 0; i < 4; i++) begin
      tick_adv(waited);
      chk("left_led", 32'(led), 32'(exp_left[i]));
    end

    // Fill
    pulse(1'b1, 1'b0, 1'b0);
    chk("fill_mode", 32'(mode), 3);
    chk("fill_start", 32'(led), 'b0000);
    for (int i = 0; i < 5; i++) begin
      tick_adv(waited);
      chk("fill_led", 32'(led), 32'(exp_fill[i]));
    end

    // Speed 3: 32-cycle tick period
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("speed3", 32'(speed), 3);
    tick_adv(waited);
    chk("s3_led_a", 32'(led), 'b0001);
    tick_adv(waited);
    chk("s3_wait", 32'(waited), 31);
    chk("s3_led_b", 32'(led), 'b0011);

    // Wrap to speed 0; prescaler keeps counting (cnt%4==1 here, so next tick is 2 cycles away)
    pulse(1'b0, 1'b1, 1'b0);
    chk("speed_wrap", 32'(speed), 0);
    tick_adv(waited);
    chk("s0_wait_nocl", 32'(waited), 2);
    chk("s0_led_a", 32'(led), 'b0111);
    tick_adv(waited);
    chk("s0_wait", 32'(waited), 3);
    chk("s0_led_b", 32'(led), 'b1111);

    // Pause: LED frozen while TICK keeps pulsing
    pulse(1'b0, 1'b0, 1'b1);
    chk("pause_on", 32'(paused), 1);
    for (int i = 0; i < 10; i++) begin
      tick_adv(waited);
      chk("pause_frozen", 32'(led), 'b1111);
    end
    pulse(1'b0, 1'b0, 1'b1);
    chk("pause_off", 32'(paused), 0);
    tick_adv(waited);
    chk("resume_led", 32'(led), 'b0000);

    // Pause toggle coincident with TICK while running: that tick still advances
    wait_tick(waited);
    pulse(1'b0, 1'b0, 1'b1);
    chk("pt_tick_led", 32'(led), 'b0001);
    chk("pt_tick_paused", 32'(paused), 1);
    for (int i = 0; i < 2; i++) begin
      tick_adv(waited);
      chk("pt_frozen", 32'(led), 'b0001);
    end
    // Resume coincident with TICK: old PAUSED=1 blocks that tick
    wait_tick(waited);
    pulse(1'b0, 1'b0, 1'b1);
    chk("rs_tick_led", 32'(led), 'b0001);
    chk("rs_tick_paused", 32'(paused), 0);
    tick_adv(waited);
    chk("rs_next_led", 32'(led), 'b0011);

    // Mode wrap 3->0, then MODE_STEP coincident with TICK at bounce pos 2
    pulse(1'b1, 1'b0, 1'b0);
    chk("mode_wrap", 32'(mode), 0);
    chk("mode_wrap_led", 32'(led), 'b0001);
    tick_adv(waited);
    chk("b2_led_a", 32'(led), 'b0010);
    tick_adv(waited);
    chk("b2_led_b", 32'(led), 'b0100);
    wait_tick(waited);
    pulse(1'b1, 1'b0, 1'b0);
    chk("ms_tick_mode", 32'(mode), 1);
    chk("ms_tick_led", 32'(led), 'b1000);
    tick_adv(waited);
    chk("ms_tick_next", 32'(led), 'b0100);

    // Reset mid-fill with all step pulses pending
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    tick_adv(waited);
    tick_adv(waited);
    chk("mf_mode", 32'(mode), 3);
    chk("mf_led", 32'(led), 'b0011);
    pulse(1'b0, 1'b1, 1'b1);
    chk("mf_speed", 32'(speed), 1);
    chk("mf_paused", 32'(paused), 1);
    rst        = 1'b1;
    mode_step  = 1'b1;
    speed_step = 1'b1;
    pause_tgl  = 1'b1;
    step();
    rst        = 1'b0;
    mode_step  = 1'b0;
    speed_step = 1'b0;
    pause_tgl  = 1'b0;
    chk("rr_led",    32'(led),     'b0001);
    chk("rr_mode",   32'(mode),    0);
    chk("rr_speed",  32'(speed),   0);
    chk("rr_paused", 32'(paused),  0);
    chk("rr_pos",    32'(pos_dbg), 0);
    tick_adv(waited);
    chk("rr_wait", 32'(waited), 3);
    chk("rr_led_next", 32'(led), 'b0010);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
